piece_queue: RTL and testbench
==============================

# piece_queue

Buffers upcoming tetrominoes between the `pieces` generator and the game controller FSM. Prefetches pieces into a DEPTH-entry preview FIFO by driving the generator's newpiece strobe, serves spawn requests, and implements the hold slot with the once-per-drop lock rule. The game FSM talks only to this block for piece identity.

## Interface
- DEPTH, 3: preview FIFO entries, legal range 1..5.
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- gen_ready  in  1  generator has a valid piece (generator ready).
- gen_piece  in  3  current generator piece, 0..6.
- gen_next  out  1  one-cycle strobe, advance generator (drives newpiece).
- spawn_req  in  1  one-cycle pulse, game FSM wants a new active piece.
- hold_req  in  1  one-cycle pulse, swap active piece with hold slot.
- lock_done  in  1  one-cycle pulse, active piece has locked; re-arms hold.
- spawn_ack  out  1  one-cycle pulse, spawn_piece is the new active piece.
- spawn_piece  out  3  registered new active piece, stable until next ack.
- preview  out  3*DEPTH  FIFO contents, entry 0 (head) in bits [2:0].
- preview_valid  out  DEPTH  bit i set when entry i is occupied.
- hold_piece  out  3  hold slot contents.
- hold_valid  out  1  hold slot occupied.
- hold_locked  out  1  hold used since last lock_done.

## Operation
- Reset values: all outputs 0; FIFO empty; no active piece; fetch FSM in F_IDLE; no pending spawn.
- Fetch FSM, three states:
  - F_IDLE: if gen_ready and count<DEPTH, write gen_piece at tail, set gen_next<=1, go F_PULSE; else stay.
  - F_PULSE: gen_next<=0, go F_WAIT.
  - F_WAIT: go F_IDLE.
  - Max one fetch per 3 cycles; gen_next is high for exactly one cycle per fetch.
- Spawn: spawn_req sets a pending flag. When pending and count>0, pop head into spawn_piece and active register, pulse spawn_ack, and clear pending. A spawn_req while pending is absorbed, with no double spawn.
- Hold: evaluated only when no spawn is pending. hold_req is ignored when hold_locked=1 or no active piece exists.
  - Hold empty: hold_piece<=active and hold_valid<=1. Set pending internally, so the head is popped and acked as a normal spawn.
  - Hold full: spawn_piece<=hold_piece, hold_piece<=active, active<=old hold, spawn_ack pulses next cycle. No FIFO pop.
  - Both cases set hold_locked<=1.
- lock_done clears hold_locked on the next edge.
- FIFO: a pop shifts entries toward head. A fetch write in the same cycle as a pop lands at index count-1, so count is unchanged. The full check uses pre-edge count.

## Timing
- Spawn latency: spawn_req at edge N with count>0 gives spawn_ack high during cycle N+1. If the FIFO is empty, spawn_ack comes the cycle after the first fetch write.
- Hold-swap latency: hold_req at edge N gives spawn_ack during cycle N+1.
- Hold-empty latency: same as spawn, gated by FIFO occupancy.
- Simultaneous events:
  - spawn_req and hold_req in the same cycle: spawn wins and hold_req is dropped.
  - hold_req and lock_done in the same cycle: hold is judged on the pre-edge lock. If it was locked, hold is ignored and lock clears. If unlocked, hold is accepted and hold_locked ends at 1.
  - lock_done with no hold used: no effect.
- gen_ready low: the fetch FSM stalls in F_IDLE, while spawns continue from buffered entries.
- Reset asserted mid-fetch or mid-spawn: all state returns to reset values on that edge, including gen_next. Any pending ack is lost.
- Post-reset fill: the first fetch is captured at the first edge after reset deasserts with gen_ready=1. The FIFO is full (DEPTH=3) after 7 cycles.

## Test plan
- Reset, gen_ready=1, generator sequence 2,5,1,6:
  - gen_next pulses at cycles 1, 4, 7 relative to the first capture edge.
  - preview_valid=3'b111 and preview={1,5,2}.
  - The generator is not strobed again.
- FIFO full {2,5,1}, spawn_req pulse:
  - spawn_ack pulses the next cycle with spawn_piece=2.
  - preview becomes {6,1,5} after the refill completes.
- Active=2, hold empty, hold_req:
  - hold_piece=2, hold_valid=1, spawn_piece=5, hold_locked=1.
  - A second hold_req produces no ack.
  - Then lock_done, then hold_req: spawn_piece=2, hold_piece=5, no FIFO pop.
- gen_ready=0 after reset, spawn_req pulse:
  - No ack while empty.
  - Raise gen_ready with gen_piece=4: spawn_ack follows the first fetch with spawn_piece=4.
- spawn_req and hold_req in the same cycle with hold unlocked: exactly one ack with head piece; hold_valid unchanged.
- Reset asserted the cycle gen_next is high: the next cycle shows gen_next=0, preview_valid=0, hold_valid=0, spawn_ack=0.

Source files
------------

// File: rtl/piece_queue.sv
// -----------------------------------------------------------------------------
// piece_queue
//
// Sits between the tetromino generator and the game controller FSM. It keeps
// a small preview FIFO topped up from the generator, hands out new active
// pieces on request, and runs the hold slot, which may be used once per drop.
//
// Parameters
//   DEPTH          preview FIFO entries (legal range 1..5)
//
// Ports
//   clk            system clock, all state on posedge
//   reset          synchronous, active-high reset
//   gen_ready      generator presents a valid piece on gen_piece
//   gen_piece      generator's current piece id (0..6)
//   gen_next       one-cycle strobe asking the generator to advance
//   spawn_req      one-cycle pulse: game FSM wants a new active piece
//   hold_req       one-cycle pulse: swap the active piece with the hold slot
//   lock_done      one-cycle pulse: active piece locked, hold is re-armed
//   spawn_ack      one-cycle pulse: spawn_piece is the new active piece
//   spawn_piece    new active piece, stable until the next spawn_ack
//   preview        FIFO contents, entry 0 (head) in bits [2:0]
//   preview_valid  bit i set when FIFO entry i is occupied
//   hold_piece     hold slot contents
//   hold_valid     hold slot occupied
//   hold_locked    hold already used since the last lock_done
// -----------------------------------------------------------------------------
module piece_queue #(
  parameter int DEPTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gen_ready,
  input  logic [2:0]         gen_piece,
  output logic               gen_next,
  input  logic               spawn_req,
  input  logic               hold_req,
  input  logic               lock_done,
  output logic               spawn_ack,
  output logic [2:0]         spawn_piece,
  output logic [3*DEPTH-1:0] preview,
  output logic [DEPTH-1:0]   preview_valid,
  output logic [2:0]         hold_piece,
  output logic               hold_valid,
  output logic               hold_locked
);

  // Wide enough to hold the value DEPTH itself (a full FIFO).
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    F_IDLE,
    F_PULSE,
    F_WAIT
  } fetch_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_e       fstate_q, fstate_d;
  logic               gen_next_q, gen_next_d;

  // FIFO kept as one packed vector: entry i lives in bits [3*i +: 3], so a
  // pop is simply a right shift by one entry.
  logic [3*DEPTH-1:0] fifo_q, fifo_d;
  logic [CW-1:0]      count_q, count_d;

  logic               pending_q, pending_d;
  logic [2:0]         active_q, active_d;
  logic               active_valid_q, active_valid_d;

  logic               spawn_ack_q, spawn_ack_d;
  logic [2:0]         spawn_piece_q, spawn_piece_d;
  logic [2:0]         hold_piece_q, hold_piece_d;
  logic               hold_valid_q, hold_valid_d;
  logic               hold_locked_q, hold_locked_d;

  // ---------------------------------------------------------------------------
  // Decode of this cycle's events
  // ---------------------------------------------------------------------------
  logic               fetch_en;
  logic               hold_ok;
  logic               hold_park;
  logic               hold_swap;
  logic               want_spawn;
  logic               pop;
  logic [CW-1:0]      wr_idx;

  // Hold is only considered when nothing is waiting to spawn, so a spawn_req
  // in the same cycle wins and the hold request is simply dropped. The lock
  // test uses the pre-edge hold_locked, so a simultaneous lock_done does not
  // re-arm hold in time for this request.
  assign hold_ok   = hold_req && !spawn_req && !pending_q &&
                     !hold_locked_q && active_valid_q;
  assign hold_park = hold_ok && !hold_valid_q;
  assign hold_swap = hold_ok &&  hold_valid_q;

  // Parking the active piece into an empty hold slot needs a replacement from
  // the FIFO, which is exactly a normal spawn.
  assign want_spawn = pending_q || spawn_req || hold_park;
  assign pop        = want_spawn && (count_q != '0);

  // A fetch that coincides with a pop lands one slot lower, since the shift
  // has already moved everything toward the head.
  assign wr_idx = pop ? (count_q - CW'(1)) : count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    fstate_d       = fstate_q;
    gen_next_d     = 1'b0;
    fetch_en       = 1'b0;
    fifo_d         = fifo_q;
    count_d        = count_q;
    pending_d      = 1'b0;
    active_d       = active_q;
    active_valid_d = active_valid_q;
    spawn_ack_d    = 1'b0;
    spawn_piece_d  = spawn_piece_q;
    hold_piece_d   = hold_piece_q;
    hold_valid_d   = hold_valid_q;
    hold_locked_d  = hold_locked_q;

    // Fetch FSM: capture, then two idle cycles so the generator sees a clean
    // one-cycle newpiece strobe and has time to present its next piece.
    // The full check uses the pre-edge count, so a pop this cycle does not
    // open a slot until the next fetch window.
    unique case (fstate_q)
      F_IDLE: begin
        if (gen_ready && (count_q < CW'(DEPTH))) begin
          fetch_en   = 1'b1;
          gen_next_d = 1'b1;
          fstate_d   = F_PULSE;
        end
      end
      F_PULSE: fstate_d = F_WAIT;
      F_WAIT:  fstate_d = F_IDLE;
      default: fstate_d = F_IDLE;
    endcase

    // FIFO: shift first, then drop the fetched piece at the tail.
    if (pop) begin
      fifo_d = fifo_q >> 3;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (fetch_en && (wr_idx == CW'(i))) begin
        fifo_d[3*i +: 3] = gen_piece;
      end
    end

    unique case ({fetch_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Spawn: a request stays pending until the FIFO has something to give.
    // Further requests while pending fold into the same flag.
    if (pop) begin
      spawn_piece_d  = fifo_q[2:0];
      active_d       = fifo_q[2:0];
      active_valid_d = 1'b1;
      spawn_ack_d    = 1'b1;
    end else begin
      pending_d = want_spawn;
    end

    // Hold into an empty slot; the replacement comes through the pop above.
    if (hold_park) begin
      hold_piece_d = active_q;
      hold_valid_d = 1'b1;
    end

    // Hold with a full slot: straight exchange, the FIFO is untouched.
    if (hold_swap) begin
      spawn_piece_d = hold_piece_q;
      hold_piece_d  = active_q;
      active_d      = hold_piece_q;
      spawn_ack_d   = 1'b1;
    end

    // An accepted hold always ends locked, even if lock_done arrives now.
    if (hold_ok) begin
      hold_locked_d = 1'b1;
    end else if (lock_done) begin
      hold_locked_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fstate_q       <= F_IDLE;
      gen_next_q     <= 1'b0;
      // NOTE: the FIFO storage is reset as well because preview exposes it
      // directly and must read as zero after reset.
      fifo_q         <= '0;
      count_q        <= '0;
      pending_q      <= 1'b0;
      active_q       <= 3'd0;
      active_valid_q <= 1'b0;
      spawn_ack_q    <= 1'b0;
      spawn_piece_q  <= 3'd0;
      hold_piece_q   <= 3'd0;
      hold_valid_q   <= 1'b0;
      hold_locked_q  <= 1'b0;
    end else begin
      fstate_q       <= fstate_d;
      gen_next_q     <= gen_next_d;
      fifo_q         <= fifo_d;
      count_q        <= count_d;
      pending_q      <= pending_d;
      active_q       <= active_d;
      active_valid_q <= active_valid_d;
      spawn_ack_q    <= spawn_ack_d;
      spawn_piece_q  <= spawn_piece_d;
      hold_piece_q   <= hold_piece_d;
      hold_valid_q   <= hold_valid_d;
      hold_locked_q  <= hold_locked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    preview_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      preview_valid[i] = (CW'(i) < count_q);
    end
  end

  assign gen_next    = gen_next_q;
  assign preview     = fifo_q;
  assign spawn_ack   = spawn_ack_q;
  assign spawn_piece = spawn_piece_q;
  assign hold_piece  = hold_piece_q;
  assign hold_valid  = hold_valid_q;
  assign hold_locked = hold_locked_q;

endmodule

// File: tb/tb_piece_queue.sv
// -----------------------------------------------------------------------------
// tb_piece_queue
//
// Directed bench for piece_queue with DEPTH=3. Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from the
// capturing edge. A tiny generator model advances its sequence each time it
// sees gen_next high and restarts at index 0 while reset is asserted.
// -----------------------------------------------------------------------------
module tb_piece_queue;

  localparam int DEPTH = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               gen_ready;
  logic [2:0]         gen_piece;
  logic               gen_next;
  logic               spawn_req;
  logic               hold_req;
  logic               lock_done;
  logic               spawn_ack;
  logic [2:0]         spawn_piece;
  logic [3*DEPTH-1:0] preview;
  logic [DEPTH-1:0]   preview_valid;
  logic [2:0]         hold_piece;
  logic               hold_valid;
  logic               hold_locked;

  int checks   = 0;
  int failures = 0;

  // Generator model
  logic [2:0] gen_seq [8];
  logic [2:0] gen_idx = 3'd0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset)         gen_idx = 3'd0;
    else if (gen_next) gen_idx = gen_idx + 3'd1;
  end

  assign gen_piece = gen_seq[gen_idx];

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .gen_ready     (gen_ready),
    .gen_piece     (gen_piece),
    .gen_next      (gen_next),
    .spawn_req     (spawn_req),
    .hold_req      (hold_req),
    .lock_done     (lock_done),
    .spawn_ack     (spawn_ack),
    .spawn_piece   (spawn_piece),
    .preview       (preview),
    .preview_valid (preview_valid),
    .hold_piece    (hold_piece),
    .hold_valid    (hold_valid),
    .hold_locked   (hold_locked)
  );

  // ---------------------------------------------------------------------------
  // Reset holds every output at zero, even with gen_ready high.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; gen_ready = 1'b1;
    spawn_req = 1'b0; hold_req = 1'b0; lock_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (gen_next !== 1'b0) begin
      failures++; $display("FAIL reset_gen_next: got %b expected 0", gen_next);
    end
    checks++;
    if (preview_valid !== 3'b000 || preview !== 9'd0) begin
      failures++;
      $display("FAIL reset_fifo: got valid=%b preview=%h expected 0/0", preview_valid, preview);
    end
    checks++;
    if (spawn_ack !== 1'b0 || spawn_piece !== 3'd0) begin
      failures++;
      $display("FAIL reset_spawn: got ack=%b piece=%0d expected 0/0", spawn_ack, spawn_piece);
    end
    checks++;
    if (hold_valid !== 1'b0 || hold_locked !== 1'b0 || hold_piece !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold: got v=%b l=%b p=%0d expected 0/0/0", hold_valid, hold_locked, hold_piece);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Post-reset fill with sequence 2,5,1,6: fetches at 0,3,6 then stop.
  // ---------------------------------------------------------------------------
  task automatic test_fill();
    logic [11:0] seen;
    seen = '0;
    reset = 1'b1; gen_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; gen_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen[k] = gen_next;
    end
    checks++;
    if (seen !== 12'b0000_0100_1001) begin
      failures++; $display("FAIL fill_gen_next_pattern: got %b expected 000001001001", seen);
    end
    checks++;
    if (preview_valid !== 3'b111) begin
      failures++; $display("FAIL fill_valid: got %b expected 111", preview_valid);
    end
    checks++;
    if (preview !== {3'd1, 3'd5, 3'd2}) begin
      failures++; $display("FAIL fill_preview: got %h expected %h", preview, {3'd1, 3'd5, 3'd2});
    end
    #1;
    checks++;
    if (gen_idx !== 3'd3) begin
      failures++; $display("FAIL fill_strobe_count: got %0d expected 3", gen_idx);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Spawn from a full FIFO {2,5,1}; refill brings in 6.
  // ---------------------------------------------------------------------------
  task automatic test_spawn();
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    checks++;
    if (spawn_ack !== 1'b1 || spawn_piece !== 3'd2) begin
      failures++;
      $display("FAIL spawn_ack: got ack=%b piece=%0d expected 1/2", spawn_ack, spawn_piece);
    end
    checks++;
    if (preview_valid !== 3'b011 || preview !== {3'd0, 3'd1, 3'd5}) begin
      failures++;
      $display("FAIL spawn_pop: got valid=%b preview=%h expected 011/%h", preview_valid, preview, {3'd0, 3'd1, 3'd5});
    end
    @(negedge clk);
    checks++;
    if (spawn_ack !== 1'b0 || gen_next !== 1'b1 || spawn_piece !== 3'd2) begin
      failures++;
      $display("FAIL spawn_after: got ack=%b gen_next=%b piece=%0d expected 0/1/2", spawn_ack, gen_next, spawn_piece);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (preview_valid !== 3'b111 || preview !== {3'd6, 3'd1, 3'd5}) begin
      failures++;
      $display("FAIL spawn_refill: got valid=%b preview=%h expected 111/%h", preview_valid, preview, {3'd6, 3'd1, 3'd5});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Hold: park into empty slot, locked retry, re-arm, swap, locked+lock_done.
  // ---------------------------------------------------------------------------
  task automatic test_hold();
    logic any_ack;
    hold_req = 1'b1;
    @(negedge clk);
    hold_req = 1'b0;
    checks++;
    if (spawn_ack !== 1'b1 || spawn_piece !== 3'd5) begin
      failures++;
      $display("FAIL hold_park_ack: got ack=%b piece=%0d expected 1/5", spawn_ack, spawn_piece);
    end
    checks++;
    if (hold_piece !== 3'd2 || hold_valid !== 1'b1 || hold_locked !== 1'b1) begin
      failures++;
      $display("FAIL hold_park_slot: got p=%0d v=%b l=%b expected 2/1/1", hold_piece, hold_valid, hold_locked);
    end
    checks++;
    if (preview_valid !== 3'b011) begin
      failures++; $display("FAIL hold_park_pop: got %b expected 011", preview_valid);
    end
    repeat (4) @(negedge clk);

    // Second hold while locked: ignored.
    any_ack = 1'b0;
    hold_req = 1'b1;
    @(negedge clk);
    hold_req = 1'b0;
    any_ack |= spawn_ack;
    repeat (2) begin
      @(negedge clk);
      any_ack |= spawn_ack;
    end
    checks++;
    if (any_ack !== 1'b0 || hold_piece !== 3'd2 || preview_valid !== 3'b111) begin
      failures++;
      $display("FAIL hold_locked_ignored: got ack=%b p=%0d valid=%b expected 0/2/111", any_ack, hold_piece, preview_valid);
    end

    lock_done = 1'b1;
    @(negedge clk);
    lock_done = 1'b0;
    checks++;
    if (hold_locked !== 1'b0) begin
      failures++; $display("FAIL hold_rearm: got %b expected 0", hold_locked);
    end

    // Swap with full slot: no FIFO pop.
    hold_req = 1'b1;
    @(negedge clk);
    hold_req = 1'b0;
    checks++;
    if (spawn_ack !== 1'b1 || spawn_piece !== 3'd2 || hold_piece !== 3'd5 || hold_locked !== 1'b1) begin
      failures++;
      $display("FAIL hold_swap: got ack=%b piece=%0d hold=%0d l=%b expected 1/2/5/1", spawn_ack, spawn_piece, hold_piece, hold_locked);
    end
    checks++;
    if (preview_valid !== 3'b111 || preview !== {3'd3, 3'd6, 3'd1}) begin
      failures++;
      $display("FAIL hold_swap_nopop: got valid=%b preview=%h expected 111/%h", preview_valid, preview, {3'd3, 3'd6, 3'd1});
    end

    // hold_req with lock_done while locked: hold ignored, lock clears.
    hold_req = 1'b1; lock_done = 1'b1;
    @(negedge clk);
    hold_req = 1'b0; lock_done = 1'b0;
    checks++;
    if (spawn_ack !== 1'b0 || hold_locked !== 1'b0 || hold_piece !== 3'd5) begin
      failures++;
      $display("FAIL hold_locked_with_lock_done: got ack=%b l=%b p=%0d expected 0/0/5", spawn_ack, hold_locked, hold_piece);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Simultaneous events with hold unlocked.
  // ---------------------------------------------------------------------------
  task automatic test_same_cycle();
    spawn_req = 1'b1; hold_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0; hold_req = 1'b0;
    checks++;
    if (spawn_ack !== 1'b1 || spawn_piece !== 3'd1) begin
      failures++;
      $display("FAIL same_spawn_wins: got ack=%b piece=%0d expected 1/1", spawn_ack, spawn_piece);
    end
    checks++;
    if (hold_valid !== 1'b1 || hold_piece !== 3'd5 || hold_locked !== 1'b0) begin
      failures++;
      $display("FAIL same_hold_dropped: got v=%b p=%0d l=%b expected 1/5/0", hold_valid, hold_piece, hold_locked);
    end
    @(negedge clk);
    checks++;
    if (spawn_ack !== 1'b0) begin
      failures++; $display("FAIL same_single_ack: got %b expected 0", spawn_ack);
    end
    repeat (3) @(negedge clk);

    // hold_req with lock_done while unlocked: swap accepted, ends locked.
    hold_req = 1'b1; lock_done = 1'b1;
    @(negedge clk);
    hold_req = 1'b0; lock_done = 1'b0;
    checks++;
    if (spawn_ack !== 1'b1 || spawn_piece !== 3'd5 || hold_piece !== 3'd1 || hold_locked !== 1'b1) begin
      failures++;
      $display("FAIL same_hold_lock_done: got ack=%b piece=%0d hold=%0d l=%b expected 1/5/1/1", spawn_ack, spawn_piece, hold_piece, hold_locked);
    end
    checks++;
    if (preview !== {3'd4, 3'd3, 3'd6}) begin
      failures++; $display("FAIL same_preview: got %h expected %h", preview, {3'd4, 3'd3, 3'd6});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reset asserted in the cycle gen_next is high.
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    spawn_req = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      spawn_req = 1'b0;
      if (gen_next === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL reset_mid_wait_fetch: got no gen_next within 8 cycles expected one");
    end else begin
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (gen_next !== 1'b0 || spawn_ack !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_strobes: got gen_next=%b ack=%b expected 0/0", gen_next, spawn_ack);
      end
      checks++;
      if (preview_valid !== 3'b000 || hold_valid !== 1'b0 || hold_locked !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_state: got valid=%b hv=%b hl=%b expected 000/0/0", preview_valid, hold_valid, hold_locked);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Spawn requested on an empty FIFO with the generator stalled.
  // ---------------------------------------------------------------------------
  task automatic test_empty_spawn();
    logic any_ack;
    gen_seq[0] = 3'd4;
    reset = 1'b1; gen_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    spawn_req = 1'b1;
    @(negedge clk);
    spawn_req = 1'b0;
    any_ack = spawn_ack;
    repeat (4) begin
      @(negedge clk);
      any_ack |= spawn_ack;
    end
    checks++;
    if (any_ack !== 1'b0 || preview_valid !== 3'b000 || gen_next !== 1'b0) begin
      failures++;
      $display("FAIL empty_no_ack: got ack=%b valid=%b gen_next=%b expected 0/000/0", any_ack, preview_valid, gen_next);
    end
    gen_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (spawn_ack !== 1'b0 || preview_valid !== 3'b001 || gen_next !== 1'b1) begin
      failures++;
      $display("FAIL empty_first_fetch: got ack=%b valid=%b gen_next=%b expected 0/001/1", spawn_ack, preview_valid, gen_next);
    end
    @(negedge clk);
    checks++;
    if (spawn_ack !== 1'b1 || spawn_piece !== 3'd4 || preview_valid !== 3'b000) begin
      failures++;
      $display("FAIL empty_late_ack: got ack=%b piece=%0d valid=%b expected 1/4/000", spawn_ack, spawn_piece, preview_valid);
    end
    @(negedge clk);
    checks++;
    if (spawn_ack !== 1'b0 || spawn_piece !== 3'd4) begin
      failures++;
      $display("FAIL empty_ack_once: got ack=%b piece=%0d expected 0/4", spawn_ack, spawn_piece);
    end
  endtask

  initial begin
    gen_seq[0] = 3'd2; gen_seq[1] = 3'd5; gen_seq[2] = 3'd1; gen_seq[3] = 3'd6;
    gen_seq[4] = 3'd3; gen_seq[5] = 3'd4; gen_seq[6] = 3'd0; gen_seq[7] = 3'd2;
    reset = 1'b1; gen_ready = 1'b0;
    spawn_req = 1'b0; hold_req = 1'b0; lock_done = 1'b0;

    test_reset();
    test_fill();
    test_spawn();
    test_hold();
    test_same_cycle();
    test_reset_mid();
    test_empty_spawn();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
